// File: rtl/bp_io_req_arbiter.sv
// bp_io_req_arbiter
// Round-robin arbiter that funnels several BedRock burst LCE-request sources
// into one uncached IO request path. Multi-beat bursts are atomic: once the
// first beat of a burst is accepted, the grant stays with that requester
// until its last beat.
// Optional feature macro: BP_IO_ARB_CREDIT_EN enables a credit counter that
// bounds in-flight IO requests. Credits are returned by cmd_done_i. When the
// macro is undefined, credits are always available and cmd_done_i is ignored.
module bp_io_req_arbiter #(
    parameter int num_req_p         = 2,
    parameter int header_width_p    = 64,
    parameter int data_width_p      = 64,
    parameter int max_outstanding_p = 4
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic [num_req_p*header_width_p-1:0]    req_header_i,
    input  logic [num_req_p*data_width_p-1:0]      req_data_i,
    input  logic [num_req_p-1:0]                   req_v_i,
    input  logic [num_req_p-1:0]                   req_last_i,
    output logic [num_req_p-1:0]                   req_ready_and_o,
    output logic [header_width_p-1:0]              arb_header_o,
    output logic [data_width_p-1:0]                arb_data_o,
    output logic                                   arb_v_o,
    output logic                                   arb_last_o,
    input  logic                                   arb_ready_and_i,
    output logic [$clog2(num_req_p)-1:0]           grant_id_o,
    input  logic                                   cmd_done_i,
    output logic [$clog2(max_outstanding_p+1)-1:0] credits_o
);

    localparam int id_w   = $clog2(num_req_p);
    localparam int cred_w = $clog2(max_outstanding_p + 1);
    localparam logic [cred_w-1:0] max_cred = cred_w'(max_outstanding_p);

    typedef enum logic {e_idle, e_burst} state_e;

    state_e          state, state_n;
    logic [id_w-1:0] rr_ptr;
    logic [id_w-1:0] lock_id;
    logic [id_w-1:0] winner;
    logic [id_w-1:0] sel_id;
    logic            any_v;
    logic            credit_ok;
    logic            hs;
    logic            first_hs;
    int              idx;

    // Round-robin pick: first asserted requester after rr_ptr, wrapping around.
    always_comb begin
        winner = rr_ptr;
        any_v  = 1'b0;
        idx    = 0;
        for (int k = num_req_p; k >= 1; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= num_req_p) idx = idx - num_req_p;
            if (req_v_i[id_w'(idx)]) begin
                winner = id_w'(idx);
                any_v  = 1'b1;
            end
        end
    end

    // While a burst is in progress the mux is pinned to its owner.
    assign sel_id       = (state == e_burst) ? lock_id : winner;
    assign arb_header_o = req_header_i[sel_id*header_width_p +: header_width_p];
    assign arb_data_o   = req_data_i[sel_id*data_width_p +: data_width_p];
    assign arb_last_o   = req_last_i[sel_id];
    assign grant_id_o   = sel_id;

    assign hs       = arb_v_o & arb_ready_and_i;
    assign first_hs = hs & (state == e_idle);

    // Valid/ready toward the winner; both forced low while reset is held.
    always_comb begin
        arb_v_o         = 1'b0;
        req_ready_and_o = '0;
        if (reset_n_i) begin
            if (state == e_burst) begin
                arb_v_o                  = req_v_i[lock_id];
                req_ready_and_o[lock_id] = arb_ready_and_i;
            end else if (any_v) begin
                arb_v_o                 = credit_ok;
                req_ready_and_o[winner] = arb_ready_and_i & credit_ok;
            end
        end
    end

    // Next state: lock on a non-last first beat, unlock on the last beat.
    always_comb begin
        state_n = state;
        case (state)
            e_idle:  if (hs && !arb_last_o) state_n = e_burst;
            e_burst: if (hs && arb_last_o)  state_n = e_idle;
        endcase
    end

    // State register; reset abandons any partial burst.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state <= e_idle;
        else            state <= state_n;
    end

    // Priority pointer and burst owner are captured on each first beat.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_ptr  <= id_w'(num_req_p - 1);
            lock_id <= '0;
        end else if (first_hs) begin
            rr_ptr <= winner;
            if (!arb_last_o) lock_id <= winner;
        end
    end

`ifdef BP_IO_ARB_CREDIT_EN
    logic [cred_w-1:0] credits;

    // One credit per message taken on its first beat, returned on completion.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            credits <= max_cred;
        else if (first_hs && !cmd_done_i)
            credits <= credits - cred_w'(1);
        else if (cmd_done_i && !first_hs && credits != max_cred)
            credits <= credits + cred_w'(1);
    end

    assign credit_ok = (credits != '0);
    assign credits_o = credits;

`ifndef SYNTHESIS
    // A completion with every credit already free means upstream lost track.
    always @(posedge clk_i) begin
        if (reset_n_i && cmd_done_i && !first_hs) assert (credits != max_cred);
    end
`endif
`else
    logic unused_cmd_done;

    assign credit_ok       = 1'b1;
    assign credits_o       = max_cred;
    assign unused_cmd_done = cmd_done_i;
`endif

endmodule
